// File: rtl/wm_pkg.sv
// Shared types and default timing constants for the programmable washing machine.
package wm_pkg;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StFill      = 4'd1,
    StDetergent = 4'd2,
    StWash      = 4'd3,
    StDrain     = 4'd4,
    StSpin      = 4'd5,
    StDone      = 4'd6,
    StFault     = 4'd7
  } wm_state_e;

  localparam int unsigned DefTimerW     = 16;
  localparam int unsigned DefWashTicks  = 1000;
  localparam int unsigned DefSpinTicks  = 500;
  localparam int unsigned DefLimitTicks = 4000;
  localparam int unsigned DefRinseMax   = 3;

  function automatic logic [1:0] clamp_rinse(logic [1:0] sel, int unsigned max_passes);
    return (32'(sel) > max_passes) ? 2'(max_passes) : sel;
  endfunction

endpackage

// File: rtl/programmable_washing_machine_if.sv
// Sensor, user and actuator signals of the washing machine controller.
interface programmable_washing_machine_if;
  logic       door_close;
  logic       start;
  logic       pause;
  logic       filled;
  logic       drained;
  logic       detergent_added;
  logic [1:0] rinse_sel;
  logic       door_lock;
  logic       motor_on;
  logic       fill_valve_on;
  logic       drain_valve_on;
  logic       soap_wash;
  logic       water_wash;
  logic       done;
  logic       fault;
  logic [3:0] state_o;
  logic [1:0] rinse_left;

  modport master (
    output door_close, start, pause, filled, drained, detergent_added, rinse_sel,
    input  door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash,
    input  done, fault, state_o, rinse_left
  );

  modport slave (
    input  door_close, start, pause, filled, drained, detergent_added, rinse_sel,
    output door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash,
    output done, fault, state_o, rinse_left
  );
endinterface

// File: rtl/wm_timer.sv
// Loadable down-counter with enable; saturates at zero and flags it.
module wm_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/programmable_washing_machine.sv
// Washing machine sequencer: fill, detergent, wash, drain, optional rinses, spin.
module programmable_washing_machine
  import wm_pkg::*;
#(
  parameter int unsigned TIMER_W     = DefTimerW,
  parameter int unsigned WASH_TICKS  = DefWashTicks,
  parameter int unsigned SPIN_TICKS  = DefSpinTicks,
  parameter int unsigned LIMIT_TICKS = DefLimitTicks,
  parameter int unsigned RINSE_MAX   = DefRinseMax
) (
  input logic                          clk,
  input logic                          reset,
  programmable_washing_machine_if.slave wm
);

  if (TIMER_W < 1 || WASH_TICKS < 1 || SPIN_TICKS < 1 || LIMIT_TICKS < 1 ||
      (WASH_TICKS >> TIMER_W) != 0 || (SPIN_TICKS >> TIMER_W) != 0 ||
      (LIMIT_TICKS >> TIMER_W) != 0 || RINSE_MAX < 1 || RINSE_MAX > 3) begin : gen_param_err
    $error("programmable_washing_machine: illegal parameter values");
  end

  wm_state_e  state_q, state_d;
  logic [1:0] rinse_q, rinse_d;
  logic       soap_q, soap_d, water_q, water_d;
  logic       locked, ph_zero, wd_zero, ph_load, wd_load, ph_en, wd_en;
  logic [TIMER_W-1:0] ph_load_val;

  assign locked = (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    state_d = state_q;
    rinse_d = rinse_q;
    soap_d  = soap_q;
    water_d = water_q;
    // An open door aborts any locked phase before anything else is considered.
    if (locked && !wm.door_close) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StIdle: begin
          if (wm.start && wm.door_close) begin
            state_d = StFill;
            rinse_d = clamp_rinse(wm.rinse_sel, RINSE_MAX);
            soap_d  = 1'b1;
            water_d = 1'b0;
          end
        end
        StFill: begin
          if (wm.filled)    state_d = soap_q ? StDetergent : StWash;
          else if (wd_zero) state_d = StFault;
        end
        StDetergent: if (wm.detergent_added) state_d = StWash;
        StWash:      if (!wm.pause && ph_zero) state_d = StDrain;
        StDrain: begin
          if (wm.drained) begin
            if (rinse_q != 2'd0) begin
              state_d = StFill;
              rinse_d = rinse_q - 2'd1;
              soap_d  = 1'b0;
              water_d = 1'b1;
            end else begin
              state_d = StSpin;
            end
          end else if (wd_zero) begin
            state_d = StFault;
          end
        end
        StSpin: if (!wm.pause && ph_zero) state_d = StDone;
        StDone: begin
          state_d = StIdle;
          soap_d  = 1'b0;
          water_d = 1'b0;
        end
        StFault: state_d = StFault;
        default: state_d = StFault;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rinse_q <= '0;
      soap_q  <= 1'b0;
      water_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rinse_q <= rinse_d;
      soap_q  <= soap_d;
      water_q <= water_d;
    end
  end

  // Timers reload on phase entry so each phase counts from a known value.
  assign ph_load     = (state_d != state_q) && ((state_d == StWash) || (state_d == StSpin));
  assign ph_load_val = (state_d == StSpin) ? TIMER_W'(SPIN_TICKS - 1) : TIMER_W'(WASH_TICKS - 1);
  assign ph_en       = ((state_q == StWash) || (state_q == StSpin)) && !wm.pause;
  assign wd_load     = (state_d != state_q) && ((state_d == StFill) || (state_d == StDrain));
  assign wd_en       = (state_q == StFill) || (state_q == StDrain);

  wm_timer #(.W(TIMER_W)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_load_val),
    .en       (ph_en),
    .zero     (ph_zero)
  );

  wm_timer #(.W(TIMER_W)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .load     (wd_load),
    .load_val (TIMER_W'(LIMIT_TICKS - 1)),
    .en       (wd_en),
    .zero     (wd_zero)
  );

  assign wm.door_lock      = locked;
  assign wm.motor_on       = ((state_q == StWash) || (state_q == StSpin)) && !wm.pause;
  assign wm.fill_valve_on  = (state_q == StFill);
  assign wm.drain_valve_on = (state_q == StDrain) || (state_q == StSpin);
  assign wm.done           = (state_q == StDone);
  assign wm.fault          = (state_q == StFault);
  assign wm.soap_wash      = soap_q;
  assign wm.water_wash     = water_q;
  assign wm.state_o        = state_q;
  assign wm.rinse_left     = rinse_q;

endmodule

// File: doc/programmable_washing_machine.md
PROGRAMMABLE_WASHING_MACHINE -- requirements
Module: programmable_washing_machine

Interface
REQ-001 Parameters SHALL be:
- TIMER_W, 16, timer counter width.
- WASH_TICKS, 1000, wash/rinse agitation length in clk cycles.
- SPIN_TICKS, 500, spin length in clk cycles.
- LIMIT_TICKS, 4000, maximum cycles allowed in FILL or DRAIN before fault.
- RINSE_MAX, 3, maximum number of rinse passes.
REQ-002 Parameters SHALL satisfy all *_TICKS >= 1 and < 2**TIMER_W, and 1 <= RINSE_MAX <= 3; a violation SHALL be an elaboration error.
REQ-003 Ports (clock and reset first) SHALL be:
- clk, in, 1, single clock; all state changes on rising edge.
- reset, in, 1, asynchronous, active-high.
- door_close, start, pause, filled, drained, detergent_added, in, 1 each, sensor/user inputs.
- rinse_sel, in, 2, requested rinse passes, sampled at start.
- door_lock, motor_on, fill_valve_on, drain_valve_on, out, 1 each, actuators.
- soap_wash, water_wash, out, 1 each, phase flags.
- done, out, 1, program complete.
- fault, out, 1, sticky error.
- state_o, out, 4, current state encoding.
- rinse_left, out, 2, rinse passes still pending.

Function
REQ-004 States SHALL be IDLE, FILL, DETERGENT, WASH, DRAIN, SPIN, DONE, FAULT.
REQ-005 IDLE->FILL when start=1 and door_close=1; rinse_left SHALL load min(rinse_sel, RINSE_MAX) and soap_wash SHALL set.
REQ-006 FILL->DETERGENT when filled=1 in the soap pass; FILL->WASH when filled=1 in a rinse pass.
REQ-007 DETERGENT->WASH when detergent_added=1.
REQ-008 WASH SHALL last exactly WASH_TICKS unpaused cycles, then go to DRAIN.
REQ-009 DRAIN with drained=1: if rinse_left>0, go to FILL, decrement rinse_left, clear soap_wash, set water_wash; otherwise go to SPIN.
REQ-010 SPIN SHALL last exactly SPIN_TICKS unpaused cycles, then go to DONE. DONE SHALL last one cycle, then go to IDLE.
REQ-011 Outputs SHALL decode from the registered state:
- fill_valve_on in FILL.
- motor_on in WASH and SPIN when pause=0.
- drain_valve_on in DRAIN and SPIN.
- door_lock in every state except IDLE and DONE.
- done in DONE only.
- fault in FAULT only.
REQ-012 pause=1 in WASH or SPIN SHALL freeze the timer and drop motor_on in the same cycle; the state SHALL be held. pause SHALL be ignored in all other states.
REQ-013 A FILL or DRAIN dwell reaching LIMIT_TICKS cycles without its sensor SHALL go to FAULT.
REQ-014 door_close=0 in any locked state SHALL go to FAULT next edge, with priority over every other transition.
REQ-015 FAULT SHALL drive all actuators off except door_lock=1, and SHALL be left only by reset.
REQ-016 start SHALL be ignored outside IDLE. A sensor asserted in a state that does not consume it SHALL be ignored.
REQ-017 The timer SHALL reload on entry to WASH or SPIN; a tick count of 1 SHALL give a single-cycle phase.

Reset
REQ-018 reset=1 SHALL force IDLE, timer 0, rinse_left 0, soap_wash/water_wash 0, and all outputs 0, including mid-cycle.
REQ-019 Deassertion SHALL take effect at the next clk edge, with no spurious transition.

Structure
REQ-020 A shared package wm_pkg SHALL hold the state enum with fixed 4-bit encodings (IDLE=0 ... FAULT=7) and the default tick constants.
REQ-021 A sub-module wm_timer SHALL implement a TIMER_W loadable down-counter with enable and zero flag; the FSM SHALL instantiate one copy for phases and one for the LIMIT watchdog.

Verification
REQ-022 Benches SHALL use WASH_TICKS=4, SPIN_TICKS=3, LIMIT_TICKS=8, RINSE_MAX=2 and cover:
- Full program, rinse_sel=1, sensors after 2 cycles -> sequence FILL, DET, WASH(4), DRAIN, FILL, WASH(4), DRAIN, SPIN(3), DONE; done high exactly one cycle.
- rinse_sel=3 -> clamped; rinse_left=2 after start; two rinse passes observed.
- pause for 5 cycles during WASH cycle 2 -> motor_on=0 for 5 cycles; WASH total 9 cycles.
- filled never asserted -> FAULT after 8 FILL cycles; fault=1, door_lock=1, fill_valve_on=0.
- door_close dropped during SPIN -> FAULT next edge; reset -> IDLE with all outputs 0.
